// File: rtl/rot_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rot_load_ctrl_if
//  Description : Handshake/bus bundle for rot_load_ctrl. The upstream byte
//                source drives in_data/in_valid and sees in_ready. The
//                downstream rotate register sees load_val/load_en. busy and
//                fifo_count are status outputs.
//  Modports    : master - the side that offers bytes and observes outputs
//                slave  - the rot_load_ctrl block itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface rot_load_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int C_CW = $clog2(DEPTH) + 1;

    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      load_val;
    logic            load_en;
    logic            busy;
    logic [C_CW-1:0] fifo_count;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  load_val,
        input  load_en,
        input  busy,
        input  fifo_count
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output load_val,
        output load_en,
        output busy,
        output fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/rot_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rot_load_ctrl
//  Description : Buffers incoming bytes in a small FIFO and feeds them one at
//                a time to a downstream rotate register. Each byte gets a
//                one-cycle load strobe followed by a rotate window of exactly
//                ROT_CYCLES cycles before the next byte may be loaded.
//  Ports       : clk  - single clock, rising edge
//                rstn - asynchronous active-low reset
//                bus  - rot_load_ctrl_if.slave (in_data, in_valid, in_ready,
//                       load_val, load_en, busy, fifo_count)
//  Parameters  : DEPTH      - FIFO entries, power of two, 2..16
//                ROT_CYCLES - rotate cycles between loads, 1..255
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_load_ctrl #(
    parameter int DEPTH      = 4,
    parameter int ROT_CYCLES = 8
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    rot_load_ctrl_if.slave   bus
);
    localparam int              C_AW       = $clog2(DEPTH);
    localparam int              C_CW       = C_AW + 1;
    localparam logic [C_CW-1:0] C_DEPTH    = C_CW'(DEPTH);
    localparam logic [7:0]      C_ROT_LAST = 8'(ROT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_ROTATE = 2'd2
    } state_t;

    state_t          r_state;
    logic [7:0]      r_rot_cnt;
    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [C_CW-1:0] r_count;
    logic [7:0]      r_mem [DEPTH];
    logic [7:0]      r_load_val;
    logic            r_load_en;
    logic            r_busy;

    logic w_ready;
    logic w_push;
    logic w_rot_last;
    logic w_pop;

    // in_ready is held low while reset is asserted; the count term alone
    // gives no fall-through, so a full FIFO refuses even on a pop edge.
    assign w_ready    = rstn && (r_count < C_DEPTH);
    assign w_push     = bus.in_valid && w_ready;
    assign w_rot_last = (r_state == S_ROTATE) && (r_rot_cnt == C_ROT_LAST);
    // Pops happen only from IDLE or at the end of a full rotate window.
    assign w_pop      = (r_count != '0) && ((r_state == S_IDLE) || w_rot_last);

    // Storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer with registered strobe, value and busy flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_rot_cnt  <= '0;
            r_load_val <= '0;
            r_load_en  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_load_val <= r_mem[r_rd_ptr];
                        r_load_en  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_load_en <= 1'b0;
                    r_rot_cnt <= '0;
                    r_state   <= S_ROTATE;
                end
                S_ROTATE: begin
                    if (w_rot_last) begin
                        if (w_pop) begin
                            r_load_val <= r_mem[r_rd_ptr];
                            r_load_en  <= 1'b1;
                            r_state    <= S_LOAD;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_rot_cnt <= r_rot_cnt + 8'd1;
                    end
                end
                default: begin
                    r_load_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.load_val   = r_load_val;
    assign bus.load_en    = r_load_en;
    assign bus.busy       = r_busy;
    assign bus.fifo_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_rot_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rot_load_ctrl
//  Description : Self-checking bench for rot_load_ctrl. A queue-based model
//                predicts outputs from load timing rules: a byte is popped at
//                an edge when one is buffered and at least ROT_CYCLES+1 edges
//                have passed since the previous pop. A second instance with
//                ROT_CYCLES=1 checks the back-to-back stream cadence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_load_ctrl;
    localparam int DEPTH = 4;
    localparam int ROT   = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rot_load_ctrl_if #(.DEPTH(DEPTH)) bus ();
    rot_load_ctrl_if #(.DEPTH(DEPTH)) bus1 ();

    rot_load_ctrl #(.DEPTH(DEPTH), .ROT_CYCLES(ROT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    rot_load_ctrl #(.DEPTH(DEPTH), .ROT_CYCLES(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [7:0] mq[$];
    int         e;
    int         last_pop;
    bit         has_pop;
    logic [7:0] m_val;

    // observation history
    logic [7:0] got[$];
    int         lt[$];
    int         cyc;
    int         peak;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       en;
        logic [7:0] val;
        int         cnt;
        logic       busy;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e        = -1;
        last_pop = 0;
        has_pop  = 0;
        m_val    = 8'h00;
        got.delete();
        lt.delete();
        cyc  = 0;
        peak = 0;
    endtask

    // One clock edge on the main instance, with model update and checks.
    task automatic step(input logic v, input logic [7:0] d, output logic acc);
        logic m_push, m_pop;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        acc = v && bus.in_ready;
        @(posedge clk);
        e++;
        cyc++;
        m_pop  = (mq.size() != 0) && (!has_pop || (e - last_pop >= ROT + 1));
        m_push = v && (mq.size() < DEPTH);
        if (m_pop) begin
            m_val    = mq.pop_front();
            last_pop = e;
            has_pop  = 1;
        end
        if (m_push) mq.push_back(d);
        #1;
        chk("in_ready",   bus.in_ready,   mq.size() < DEPTH);
        chk("load_en",    bus.load_en,    has_pop && (last_pop == e));
        chk("load_val",   bus.load_val,   m_val);
        chk("busy",       bus.busy,       has_pop && ((e - last_pop) <= ROT));
        chk("fifo_count", bus.fifo_count, mq.size());
        if (bus.load_en) begin
            got.push_back(bus.load_val);
            lt.push_back(cyc);
        end
        if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic       a;
        int         idx;
        bit         saw_full;
        int         busy_cycles;
        logic [7:0] b6[6];
        int         sent;
        int         expn;
        logic       rdy;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus1.in_valid = 1'b0;
        bus1.in_data  = 8'h00;
        model_reset();

        // reset state
        #2;
        chk("rst_in_ready", bus.in_ready,   0);
        chk("rst_load_en",  bus.load_en,    0);
        chk("rst_busy",     bus.busy,       0);
        chk("rst_count",    bus.fifo_count, 0);
        chk("rst_load_val", bus.load_val,   0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_rst_ready", bus.in_ready, 1);

        // single byte 0xA5: load after the next edge, then 9 busy cycles
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 8'hA5, 0, 1'b1};
        for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 8'hA5, 0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'hA5, 0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'hA5, 0, 1'b0};
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].d, a);
            chk("tbl_load_en",  bus.load_en,    tbl[i].en);
            chk("tbl_load_val", bus.load_val,   tbl[i].val);
            chk("tbl_count",    bus.fifo_count, tbl[i].cnt);
            chk("tbl_busy",     bus.busy,       tbl[i].busy);
            if (bus.busy) busy_cycles++;
        end
        chk("busy_cycles", busy_cycles, 9);

        // four bytes pushed while a previous byte rotates: count peaks at 4
        do_reset();
        step(1'b1, 8'hEE, a);
        idle(2);
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), a);
        idle(50);
        chk("b2b_peak", peak, 4);
        chk("b2b_nloads", got.size(), 5);
        if (got.size() == 5) begin
            chk("b2b_first", got[0], 8'hEE);
            for (int i = 1; i < 5; i++) chk("b2b_order", got[i], 8'(i));
            for (int i = 0; i < 4; i++) chk("b2b_spacing", lt[i+1] - lt[i], ROT + 1);
        end

        // six bytes with in_valid held: back-pressure, no loss or duplication
        do_reset();
        for (int i = 0; i < 6; i++) b6[i] = 8'h31 + 8'(i);
        idx = 0;
        saw_full = 0;
        for (int c = 0; c < 200 && idx < 6; c++) begin
            step(1'b1, b6[idx], a);
            if (a) idx++;
            if (bus.fifo_count == 3'd4 && !bus.in_ready) saw_full = 1;
        end
        chk("hold_all_accepted", idx, 6);
        chk("hold_full_seen", saw_full, 1);
        idle(70);
        chk("hold_nloads", got.size(), 6);
        if (got.size() == 6)
            for (int i = 0; i < 6; i++) chk("hold_order", got[i], b6[i]);

        // push and pop on the same edge with two bytes buffered
        do_reset();
        step(1'b1, 8'h10, a);
        step(1'b1, 8'h11, a);
        step(1'b1, 8'h12, a);
        idle(7);
        chk("pp_count_before", bus.fifo_count, 2);
        step(1'b1, 8'h13, a);
        chk("pp_count", bus.fifo_count, 2);
        chk("pp_load_en", bus.load_en, 1);
        chk("pp_load_val", bus.load_val, 8'h11);
        idle(30);
        chk("pp_nloads", got.size(), 4);
        if (got.size() == 4) begin
            chk("pp_order2", got[2], 8'h12);
            chk("pp_order3", got[3], 8'h13);
        end

        // asynchronous reset mid-rotate with three bytes buffered
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h20 + 8'(i), a);
        idle(2);
        chk("mid_count", bus.fifo_count, 3);
        chk("mid_busy", bus.busy, 1);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_load_en",  bus.load_en,    0);
        chk("arst_busy",     bus.busy,       0);
        chk("arst_ready",    bus.in_ready,   0);
        chk("arst_count",    bus.fifo_count, 0);
        chk("arst_load_val", bus.load_val,   0);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        #1;
        chk("arst_rel_ready", bus.in_ready, 1);
        idle(30);
        chk("arst_no_loads", got.size(), 0);
        chk("arst_final_count", bus.fifo_count, 0);

        // ROT_CYCLES=1 instance, continuous stream: load every second cycle
        do_reset();
        sent = 0;
        expn = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            bus1.in_valid = 1'b1;
            bus1.in_data  = 8'(sent);
            rdy = bus1.in_ready;
            @(posedge clk);
            #1;
            if (rdy) sent++;
            chk("r1_load_en", bus1.load_en, i % 2);
            if (bus1.load_en) begin
                chk("r1_load_val", bus1.load_val, 8'(expn));
                expn++;
            end
        end
        bus1.in_valid = 1'b0;

        // randomized traffic against the model, heavy then light
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int pct;
            pct = (i < 200) ? 70 : 15;
            step(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0, 8'($urandom), a);
        end
        idle(60);
        chk("rand_drained", bus.fifo_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
